// File: rtl/map_hub_sw_pkg.sv
// Shared types for the mapper hub: cartridge-side bundles, quiescent output value, hub states.
// Optional statistics (sw_cnt, bad_seen) are enabled with the MAP_HUB_STAT_EN macro.
package map_hub_sw_pkg;

  localparam int IDX_W  = 5;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [IDX_W-1:0] map_idx;
  } map_cfg_t;

  typedef struct packed {
    map_cfg_t cfg;
  } MapIn;

  typedef struct packed {
    logic              rom_ce;
    logic              ram_ce;
    logic              oe;
    logic              we;
    logic              data_oe;
    logic [DATA_W-1:0] data;
  } MapOut;

  // All enables and strobes low, data zero: nothing driven onto the cartridge bus.
  localparam MapOut MAP_OUT_IDLE = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    GAP   = 2'd2
  } HubState;

endpackage

// File: rtl/map_hub_sw_if.sv
// Bus-side bundle of the mapper hub; slave modport is the hub, master is the bus/IO layer.
// The sw_cnt / bad_seen members exist only when MAP_HUB_STAT_EN is defined.
interface map_hub_sw_if import map_hub_sw_pkg::*; #(
  parameter int NUM_MAP = 4
) ();

  localparam int SEL_W = $clog2(NUM_MAP);

  MapIn             mai;
  logic             bus_act;
  MapOut            mao;
  logic [SEL_W-1:0] sel_slot;
  logic             sw_busy;
  logic             idx_bad;
`ifdef MAP_HUB_STAT_EN
  logic [7:0]       sw_cnt;
  logic             bad_seen;

  modport slave  (input mai, bus_act, output mao, sel_slot, sw_busy, idx_bad, sw_cnt, bad_seen);
  modport master (output mai, bus_act, input mao, sel_slot, sw_busy, idx_bad, sw_cnt, bad_seen);
`else
  modport slave  (input mai, bus_act, output mao, sel_slot, sw_busy, idx_bad);
  modport master (output mai, bus_act, input mao, sel_slot, sw_busy, idx_bad);
`endif

endinterface

// File: rtl/map_hub_seq.sv
// Switch sequencer of the mapper hub: drains the bus, gates outputs for a gap, then commits.
// With MAP_HUB_STAT_EN defined it also keeps the switch counter and sticky bad-index flag.
//
//   state | meaning
//   RUN   | committed slot drives the bus, watching for a new target
//   DRAIN | old slot still live, waiting for IDLE_CYC consecutive idle cycles
//   GAP   | outputs forced to MAP_OUT_IDLE for GAP_CYC cycles before commit
module map_hub_seq import map_hub_sw_pkg::*; #(
  parameter int NUM_MAP  = 4,
  parameter int DEF_SLOT = 0,
  parameter int IDLE_CYC = 4,
  parameter int GAP_CYC  = 2,
  parameter int SEL_W    = $clog2(NUM_MAP)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] tgt,
  input  logic             bus_act,
`ifdef MAP_HUB_STAT_EN
  input  logic             idx_bad,
  output logic [7:0]       sw_cnt,
  output logic             bad_seen,
`endif
  output logic [SEL_W-1:0] sel_slot,
  output logic             gate,
  output logic             sw_busy
);

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYC - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYC - 1);

  HubState          state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] pend_q, pend_d;
  logic             gate_q, gate_d;
  logic [7:0]       idle_cnt_q, idle_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      sel_q      <= SEL_W'(DEF_SLOT);
      pend_q     <= SEL_W'(DEF_SLOT);
      gate_q     <= 1'b0;
      idle_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      pend_q     <= pend_d;
      gate_q     <= gate_d;
      idle_cnt_q <= idle_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    pend_d     = pend_q;
    gate_d     = gate_q;
    idle_cnt_d = idle_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    commit     = 1'b0;
    case (state_q)
      RUN: begin
        if (tgt != sel_q) begin
          pend_d     = tgt;
          idle_cnt_d = '0;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (tgt == sel_q) begin
          state_d = RUN;
        end else if (tgt != pend_q) begin
          pend_d     = tgt;
          idle_cnt_d = '0;
        end else if (bus_act) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          gate_d    = 1'b1;
          gap_cnt_d = '0;
          state_d   = GAP;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      GAP: begin
        // Outputs are already quiet here, so even a return to the old slot runs the gap out.
        if (tgt != pend_q) begin
          pend_d    = tgt;
          gap_cnt_d = '0;
        end else if (gap_cnt_q == GAP_LAST) begin
          sel_d   = pend_q;
          gate_d  = 1'b0;
          state_d = RUN;
          commit  = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = RUN;
        gate_d  = 1'b0;
      end
    endcase
  end

  assign sel_slot = sel_q;
  assign gate     = gate_q;
  assign sw_busy  = (state_q != RUN);

`ifdef MAP_HUB_STAT_EN
  logic [7:0] sw_cnt_q, sw_cnt_d;
  logic       bad_seen_q, bad_seen_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_cnt_q   <= '0;
      bad_seen_q <= 1'b0;
    end else begin
      sw_cnt_q   <= sw_cnt_d;
      bad_seen_q <= bad_seen_d;
    end
  end

  always_comb begin
    sw_cnt_d   = sw_cnt_q;
    bad_seen_d = bad_seen_q | idx_bad;
    if (commit && (pend_q != sel_q)) sw_cnt_d = sw_cnt_q + 8'd1;
  end

  assign sw_cnt   = sw_cnt_q;
  assign bad_seen = bad_seen_q;
`else
  logic unused_commit;
  assign unused_commit = commit;
`endif

endmodule

// File: rtl/map_hub_sw.sv
// Mapper hub top: decodes map_idx to a slot and muxes the committed slot onto the bus.
// Define MAP_HUB_STAT_EN to add the sw_cnt / bad_seen statistics outputs.
module map_hub_sw import map_hub_sw_pkg::*; #(
  parameter int NUM_MAP  = 4,
  parameter int DEF_SLOT = 0,
  parameter int IDLE_CYC = 4,
  parameter int GAP_CYC  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  map_hub_sw_if.slave        hub,
  input  MapOut              mout_arr [NUM_MAP]
);

  localparam int SEL_W = $clog2(NUM_MAP);

  logic [SEL_W-1:0] tgt;
  logic [SEL_W-1:0] sel_slot;
  logic             gate;
  logic             idx_bad;

  always_comb begin
    idx_bad = (32'(hub.mai.cfg.map_idx) >= 32'(NUM_MAP));
    tgt     = idx_bad ? SEL_W'(DEF_SLOT) : hub.mai.cfg.map_idx[SEL_W-1:0];
  end

  map_hub_seq #(
    .NUM_MAP  (NUM_MAP),
    .DEF_SLOT (DEF_SLOT),
    .IDLE_CYC (IDLE_CYC),
    .GAP_CYC  (GAP_CYC),
    .SEL_W    (SEL_W)
  ) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .tgt      (tgt),
    .bus_act  (hub.bus_act),
`ifdef MAP_HUB_STAT_EN
    .idx_bad  (idx_bad),
    .sw_cnt   (hub.sw_cnt),
    .bad_seen (hub.bad_seen),
`endif
    .sel_slot (sel_slot),
    .gate     (gate),
    .sw_busy  (hub.sw_busy)
  );

  assign hub.mao      = gate ? MAP_OUT_IDLE : mout_arr[sel_slot];
  assign hub.sel_slot = sel_slot;
  assign hub.idx_bad  = idx_bad;

endmodule

// File: tb/tb_map_hub_sw.sv
// Directed and randomized bench for map_hub_sw against a cycle-level behavioural model.
// Statistics checks are included when MAP_HUB_STAT_EN is defined.
module tb_map_hub_sw;
  import map_hub_sw_pkg::*;

  localparam int NUM_MAP  = 4;
  localparam int DEF_SLOT = 0;
  localparam int IDLE_CYC = 4;
  localparam int GAP_CYC  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  map_hub_sw_if #(.NUM_MAP(NUM_MAP)) hub ();
  MapOut mout_arr [NUM_MAP];

  map_hub_sw #(
    .NUM_MAP(NUM_MAP), .DEF_SLOT(DEF_SLOT), .IDLE_CYC(IDLE_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hub(hub), .mout_arr(mout_arr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0 = running, 1 = waiting for idle bus, 2 = quiet gap.
  int cur_idx = 0;
  bit cur_bus = 1'b0;
  int m_phase, m_sel, m_pend, m_idle_seen, m_gap_seen, m_cnt;
  bit m_quiet, m_bad_seen;

  function automatic int target_of(int idx);
    return (idx < NUM_MAP) ? idx : DEF_SLOT;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_sel = DEF_SLOT; m_pend = DEF_SLOT; m_quiet = 0;
    m_idle_seen = 0; m_gap_seen = 0; m_cnt = 0; m_bad_seen = 0;
  endtask

  task automatic m_step();
    int t;
    t = target_of(cur_idx);
    if (cur_idx >= NUM_MAP) m_bad_seen = 1;
    if (m_phase == 0) begin
      if (t != m_sel) begin m_pend = t; m_idle_seen = 0; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (t == m_sel) m_phase = 0;
      else if (t != m_pend) begin m_pend = t; m_idle_seen = 0; end
      else if (cur_bus) m_idle_seen = 0;
      else begin
        m_idle_seen++;
        if (m_idle_seen == IDLE_CYC) begin m_quiet = 1; m_gap_seen = 0; m_phase = 2; end
      end
    end else begin
      if (t != m_pend) begin m_pend = t; m_gap_seen = 0; end
      else begin
        m_gap_seen++;
        if (m_gap_seen == GAP_CYC) begin
          if (m_pend != m_sel) m_cnt = (m_cnt + 1) % 256;
          m_sel = m_pend; m_quiet = 0; m_phase = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_mout();
    for (int k = 0; k < NUM_MAP; k++)
      mout_arr[k] = MapOut'({1'b1, 4'($urandom), 4'(k), 4'($urandom)});
  endtask

  task automatic check_all(input string tag);
    MapOut exp_mao;
    exp_mao = m_quiet ? MAP_OUT_IDLE : mout_arr[m_sel];
    check({tag, ".mao"}, 64'(hub.mao), 64'(exp_mao));
    check({tag, ".sel"}, 64'(hub.sel_slot), 64'(m_sel));
    check({tag, ".busy"}, 64'(hub.sw_busy), 64'(m_phase != 0));
    check({tag, ".bad"}, 64'(hub.idx_bad), 64'(cur_idx >= NUM_MAP));
`ifdef MAP_HUB_STAT_EN
    check({tag, ".swcnt"}, 64'(hub.sw_cnt), 64'(m_cnt));
    check({tag, ".badseen"}, 64'(hub.bad_seen), 64'(m_bad_seen));
`endif
  endtask

  task automatic set_in(input int idx, input bit bact);
    cur_idx = idx; cur_bus = bact;
    hub.mai.cfg.map_idx = IDX_W'(idx);
    hub.bus_act = bact;
    #1;
    check_all("in");
  endtask

  task automatic cyc(input string tag);
    m_step();
    @(posedge clk);
    #1;
    refresh_mout();
    #1;
    check_all(tag);
  endtask

  task automatic settle_on(input int idx);
    set_in(idx, 1'b0);
    for (int i = 0; i < 20; i++) cyc("settle");
  endtask

  int k, busy_n, since, quiet_n, sw_before;
  bit saw_quiet;

  initial begin
    m_reset();
    refresh_mout();
    hub.mai.cfg.map_idx = IDX_W'(2);
    hub.bus_act = 1'b0;
    cur_idx = 2;

    // Power-up with map_idx = 2: slot 0 first, slot 2 after 1 + IDLE + GAP cycles.
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check_all("rel");
    check("rel.slot0", 64'(hub.mao), 64'(mout_arr[0]));
    k = 0; busy_n = 0;
    while (int'(hub.sel_slot) != 2 && k < 40) begin
      cyc("pwr");
      k++;
      if (hub.sw_busy) busy_n++;
    end
    check("pwr.latency", 64'(k), 64'(1 + IDLE_CYC + GAP_CYC));
    check("pwr.busy_cycles", 64'(busy_n), 64'(IDLE_CYC + GAP_CYC));

    // 0 -> 1 with the bus busy every third cycle.
    settle_on(0);
    cur_idx = 1;
    since = 0; saw_quiet = 0;
    for (int i = 0; i < 20; i++) begin
      cur_bus = (i % 3 == 0);
      hub.mai.cfg.map_idx = IDX_W'(1);
      hub.bus_act = cur_bus;
      cyc("pulse");
      if (hub.mao === MAP_OUT_IDLE) saw_quiet = 1;
      since = cur_bus ? 0 : since + 1;
    end
    check("pulse.no_gate", 64'(saw_quiet), 64'(0));
    set_in(1, 1'b0);
    k = 0;
    while (int'(hub.sel_slot) != 1 && k < 40) begin cyc("pulse.tail"); since++; k++; end
    check("pulse.commit_delay", 64'(since), 64'(IDLE_CYC + GAP_CYC));

    // 0 -> 3 then back to 0 two cycles into the drain: aborted, never gated.
    settle_on(0);
    saw_quiet = 0;
    set_in(3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc("abort");
      if (hub.mao === MAP_OUT_IDLE) saw_quiet = 1;
    end
    set_in(0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc("abort.back");
      if (hub.mao === MAP_OUT_IDLE) saw_quiet = 1;
    end
    check("abort.no_gate", 64'(saw_quiet), 64'(0));
    check("abort.sel", 64'(hub.sel_slot), 64'(0));

    // 0 -> 1 then 1 -> 2 on the first gap cycle: gap restarts, quiet for GAP + 1 cycles.
    settle_on(0);
    set_in(1, 1'b0);
    k = 0;
    while (hub.mao !== MAP_OUT_IDLE && k < 40) begin cyc("regap.wait"); k++; end
    check("regap.reached_gap", 64'(hub.mao === MAP_OUT_IDLE), 64'(1));
    quiet_n = 1;
    set_in(2, 1'b0);
    k = 0;
    while (k < 40) begin
      cyc("regap");
      k++;
      if (hub.mao === MAP_OUT_IDLE) quiet_n++;
      else break;
    end
    check("regap.quiet_cycles", 64'(quiet_n), 64'(GAP_CYC + 1));
    check("regap.sel", 64'(hub.sel_slot), 64'(2));

    // Out-of-range index while on the default slot: flagged, no switch.
    settle_on(0);
    sw_before = m_cnt;
    set_in(9, 1'b0);
    check("oor.idx_bad", 64'(hub.idx_bad), 64'(1));
    for (int i = 0; i < 12; i++) cyc("oor");
    check("oor.sel", 64'(hub.sel_slot), 64'(DEF_SLOT));
    check("oor.busy", 64'(hub.sw_busy), 64'(0));
`ifdef MAP_HUB_STAT_EN
    check("oor.bad_seen", 64'(hub.bad_seen), 64'(1));
    check("oor.sw_cnt", 64'(hub.sw_cnt), 64'(sw_before));
`endif

    // Reset asserted in the middle of the gap: gate drops without a clock edge.
    settle_on(0);
    set_in(1, 1'b0);
    k = 0;
    while (hub.mao !== MAP_OUT_IDLE && k < 40) begin cyc("rst.wait"); k++; end
    cyc("rst.gap");
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    check("rst.mao", 64'(hub.mao), 64'(mout_arr[0]));
    check("rst.sel", 64'(hub.sel_slot), 64'(0));
    check("rst.busy", 64'(hub.sw_busy), 64'(0));
    cur_idx = 0;
    hub.mai.cfg.map_idx = IDX_W'(0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc("rst.after");

`ifdef MAP_HUB_STAT_EN
    // 256 real switches wrap the counter back to zero.
    for (int s = 0; s < 256; s++) begin
      set_in((s % 2 == 0) ? 1 : 0, 1'b0);
      k = 0;
      while (int'(hub.sel_slot) != cur_idx && k < 20) begin cyc("wrap"); k++; end
    end
    check("wrap.sw_cnt", 64'(hub.sw_cnt), 64'(0));
`endif

    // Randomized traffic, including out-of-range indices and retargets mid-switch.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) cur_idx = $urandom_range(0, 9);
      cur_bus = ($urandom_range(0, 3) == 0);
      hub.mai.cfg.map_idx = IDX_W'(cur_idx);
      hub.bus_act = cur_bus;
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
